// File: rtl/handshake_eager_fork.sv
// Eager fork: replicates each input token to SIZE output channels, letting every
// channel accept independently and retiring the token once all have taken it.
module handshake_eager_fork #(
  parameter int SIZE      = 2,
  parameter int DATA_TYPE = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_TYPE-1:0]      ins,
  input  logic                      ins_valid,
  output logic                      ins_ready,
  output logic [SIZE*DATA_TYPE-1:0] outs,
  output logic [SIZE-1:0]           outs_valid,
  input  logic [SIZE-1:0]           outs_ready
);

  typedef enum logic {
    WAIT = 1'b0,
    DONE = 1'b1
  } chan_state_t;

  chan_state_t state_q [SIZE];
  chan_state_t state_d [SIZE];
  logic        token_retire;

  // Data is never registered: every channel sees the live input word.
  assign outs = {SIZE{ins}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SIZE; i++) state_q[i] <= WAIT;
    end else begin
      for (int unsigned i = 0; i < SIZE; i++) state_q[i] <= state_d[i];
    end
  end

  always_comb begin
    outs_valid   = '0;
    ins_ready    = 1'b1;
    token_retire = 1'b0;
    for (int unsigned i = 0; i < SIZE; i++) state_d[i] = state_q[i];

    for (int unsigned i = 0; i < SIZE; i++) begin
      outs_valid[i] = ins_valid && (state_q[i] == WAIT);
      ins_ready     = ins_ready && ((state_q[i] == DONE) || outs_ready[i]);
    end

    // Retirement takes priority so a token finishing this cycle leaves no flag behind.
    token_retire = ins_valid && ins_ready;
    for (int unsigned i = 0; i < SIZE; i++) begin
      if (token_retire)
        state_d[i] = WAIT;
      else if (outs_valid[i] && outs_ready[i])
        state_d[i] = DONE;
    end
  end

endmodule

// File: tb/tb_handshake_eager_fork.sv
// Directed bench for handshake_eager_fork with SIZE=2, 3 and 4 instances.
module tb_handshake_eager_fork;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // SIZE=2, 32-bit
  logic [31:0] ins2 = '0;
  logic        ins2_valid = 1'b0;
  logic        ins2_ready;
  logic [63:0] outs2;
  logic [1:0]  outs2_valid;
  logic [1:0]  outs2_ready = '0;

  // SIZE=3, 8-bit
  logic [7:0]  ins3 = '0;
  logic        ins3_valid = 1'b0;
  logic        ins3_ready;
  logic [23:0] outs3;
  logic [2:0]  outs3_valid;
  logic [2:0]  outs3_ready = '0;

  // SIZE=4, 32-bit
  logic [31:0]  ins4 = '0;
  logic         ins4_valid = 1'b0;
  logic         ins4_ready;
  logic [127:0] outs4;
  logic [3:0]   outs4_valid;
  logic [3:0]   outs4_ready = '0;

  handshake_eager_fork #(.SIZE(2), .DATA_TYPE(32)) dut2 (
    .clk(clk), .rst(rst), .ins(ins2), .ins_valid(ins2_valid), .ins_ready(ins2_ready),
    .outs(outs2), .outs_valid(outs2_valid), .outs_ready(outs2_ready)
  );

  handshake_eager_fork #(.SIZE(3), .DATA_TYPE(8)) dut3 (
    .clk(clk), .rst(rst), .ins(ins3), .ins_valid(ins3_valid), .ins_ready(ins3_ready),
    .outs(outs3), .outs_valid(outs3_valid), .outs_ready(outs3_ready)
  );

  handshake_eager_fork #(.SIZE(4), .DATA_TYPE(32)) dut4 (
    .clk(clk), .rst(rst), .ins(ins4), .ins_valid(ins4_valid), .ins_ready(ins4_ready),
    .outs(outs4), .outs_valid(outs4_valid), .outs_ready(outs4_ready)
  );

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    ins2 = 32'h0000_0011; ins2_valid = 1'b1; outs2_ready = 2'b00;
    #1;
    tests_run++;
    if (outs2_valid !== 2'b11) begin
      tests_failed++;
      $display("FAIL reset_valid: got %b want 11", outs2_valid);
    end
    tests_run++;
    if (ins2_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ready_low: got %b want 0", ins2_ready);
    end
    outs2_ready = 2'b11;
    #1;
    tests_run++;
    if (ins2_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready_high: got %b want 1", ins2_ready);
    end
    ins2_valid = 1'b0; outs2_ready = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ready_without_valid();
    @(negedge clk);
    ins2_valid = 1'b0; outs2_ready = 2'b11;
    #1;
    tests_run++;
    if (ins2_ready !== 1'b1 || outs2_valid !== 2'b00) begin
      tests_failed++;
      $display("FAIL ready_no_valid: got ready=%b valid=%b want ready=1 valid=00",
               ins2_ready, outs2_valid);
    end
    outs2_ready = 2'b00;
  endtask

  task automatic test_all_ready();
    @(negedge clk);
    ins2 = 32'h0000_00AA; ins2_valid = 1'b1; outs2_ready = 2'b11;
    #1;
    tests_run++;
    if (outs2_valid !== 2'b11 || ins2_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL all_ready_hs: got valid=%b ready=%b want valid=11 ready=1",
               outs2_valid, ins2_ready);
    end
    tests_run++;
    if (outs2 !== 64'h0000_00AA_0000_00AA) begin
      tests_failed++;
      $display("FAIL all_ready_data: got %h want 000000aa000000aa", outs2);
    end
    @(negedge clk);
    ins2 = 32'h0000_00AB; outs2_ready = 2'b00;
    #1;
    tests_run++;
    if (outs2_valid !== 2'b11 || ins2_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL all_ready_flags_clear: got valid=%b ready=%b want valid=11 ready=0",
               outs2_valid, ins2_ready);
    end
    outs2_ready = 2'b11;
    @(negedge clk);
    ins2_valid = 1'b0; outs2_ready = 2'b00;
  endtask

  task automatic test_partial();
    int xfer0 = 0;
    int xfer1 = 0;
    logic [1:0] exp_valid [4];
    logic       exp_ready [4];
    logic [1:0] rdy [4];
    exp_valid[0] = 2'b11; exp_ready[0] = 1'b0; rdy[0] = 2'b01;
    exp_valid[1] = 2'b10; exp_ready[1] = 1'b0; rdy[1] = 2'b01;
    exp_valid[2] = 2'b10; exp_ready[2] = 1'b0; rdy[2] = 2'b01;
    exp_valid[3] = 2'b10; exp_ready[3] = 1'b1; rdy[3] = 2'b10;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      ins2 = 32'h0000_0055; ins2_valid = 1'b1; outs2_ready = rdy[c];
      #1;
      tests_run++;
      if (outs2_valid !== exp_valid[c] || ins2_ready !== exp_ready[c]) begin
        tests_failed++;
        $display("FAIL partial_cycle%0d: got valid=%b ready=%b want valid=%b ready=%b",
                 c + 1, outs2_valid, ins2_ready, exp_valid[c], exp_ready[c]);
      end
      if (outs2_valid[0] && outs2_ready[0]) xfer0++;
      if (outs2_valid[1] && outs2_ready[1]) xfer1++;
    end
    tests_run++;
    if (xfer0 != 1 || xfer1 != 1) begin
      tests_failed++;
      $display("FAIL partial_xfers: got ch0=%0d ch1=%0d want 1 1", xfer0, xfer1);
    end
    @(negedge clk);
    outs2_ready = 2'b00;
    #1;
    tests_run++;
    if (outs2_valid !== 2'b11) begin
      tests_failed++;
      $display("FAIL partial_retired: got valid=%b want 11", outs2_valid);
    end
    ins2_valid = 1'b0;
  endtask

  task automatic test_reset_mid_token();
    @(negedge clk);
    ins2 = 32'h0000_0077; ins2_valid = 1'b1; outs2_ready = 2'b01;
    @(negedge clk);
    outs2_ready = 2'b00;
    #1;
    tests_run++;
    if (outs2_valid !== 2'b10) begin
      tests_failed++;
      $display("FAIL midrst_before: got valid=%b want 10", outs2_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (outs2_valid !== 2'b11) begin
      tests_failed++;
      $display("FAIL midrst_async: got valid=%b want 11", outs2_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    outs2_ready = 2'b11;
    #1;
    tests_run++;
    if (outs2_valid !== 2'b11 || ins2_ready !== 1'b1 || outs2 !== 64'h0000_0077_0000_0077) begin
      tests_failed++;
      $display("FAIL midrst_redeliver: got valid=%b ready=%b data=%h want 11 1 0000007700000077",
               outs2_valid, ins2_ready, outs2);
    end
    @(negedge clk);
    ins2_valid = 1'b0; outs2_ready = 2'b00;
  endtask

  task automatic test_stream();
    int tok = 1;
    int cycles = 0;
    int exp_next [3];
    int cnt [3];
    int bad [3];
    for (int i = 0; i < 3; i++) begin
      exp_next[i] = 1; cnt[i] = 0; bad[i] = 0;
    end
    while (tok <= 20 && cycles < 2000) begin
      @(negedge clk);
      ins3 = 8'(tok); ins3_valid = 1'b1;
      outs3_ready = 3'($urandom_range(0, 7));
      #1;
      for (int i = 0; i < 3; i++) begin
        if (outs3_valid[i] && outs3_ready[i]) begin
          if (int'(outs3[i*8 +: 8]) != exp_next[i]) bad[i]++;
          exp_next[i]++;
          cnt[i]++;
        end
      end
      if (ins3_ready) tok++;
      cycles++;
    end
    @(negedge clk);
    ins3_valid = 1'b0; outs3_ready = '0;
    tests_run++;
    if (tok <= 20) begin
      tests_failed++;
      $display("FAIL stream_timeout: got %0d tokens retired want 20", tok - 1);
    end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (cnt[i] != 20 || bad[i] != 0) begin
        tests_failed++;
        $display("FAIL stream_ch%0d: got count=%0d out_of_order=%0d want count=20 out_of_order=0",
                 i, cnt[i], bad[i]);
      end
    end
  endtask

  task automatic test_idle();
    int xfers = 0;
    int bad_valid = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      ins4 = 32'hDEAD_0000 + 32'(c); ins4_valid = 1'b0;
      outs4_ready = (c % 2 == 0) ? 4'b1010 : 4'b0101;
      #1;
      if (outs4_valid !== 4'b0000) bad_valid++;
      for (int i = 0; i < 4; i++) if (outs4_valid[i] && outs4_ready[i]) xfers++;
    end
    tests_run++;
    if (bad_valid != 0 || xfers != 0) begin
      tests_failed++;
      $display("FAIL idle_quiet: got bad_valid_cycles=%0d transfers=%0d want 0 0", bad_valid, xfers);
    end
    @(negedge clk);
    ins4_valid = 1'b1; outs4_ready = 4'b0000;
    #1;
    tests_run++;
    if (outs4_valid !== 4'b1111 || ins4_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_flags_clear: got valid=%b ready=%b want 1111 0", outs4_valid, ins4_ready);
    end
    outs4_ready = 4'b1111;
    #1;
    tests_run++;
    if (ins4_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL idle_all_ready: got ready=%b want 1", ins4_ready);
    end
    @(negedge clk);
    ins4_valid = 1'b0; outs4_ready = '0;
  endtask

  initial begin
    test_reset();
    test_ready_without_valid();
    test_all_ready();
    test_partial();
    test_reset_mid_token();
    test_stream();
    test_idle();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/handshake_eager_fork.md
HANDSHAKE_EAGER_FORK -- requirements
Module: handshake_eager_fork

Interface
REQ-001 The block SHALL have parameter SIZE, default 2, giving the number of output channels (legal range 2..16).
REQ-002 The block SHALL have parameter DATA_TYPE, default 32, giving the data width per channel in bits.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 Port ins, input, DATA_TYPE bits: input token data.
REQ-006 Port ins_valid, input, 1 bit: input token present.
REQ-007 Port ins_ready, output, 1 bit: input token consumed this cycle when high together with ins_valid.
REQ-008 Port outs, output, SIZE*DATA_TYPE bits: channel i occupies bits [i*DATA_TYPE +: DATA_TYPE].
REQ-009 Port outs_valid, output, SIZE bits: bit i is the valid of channel i.
REQ-010 Port outs_ready, input, SIZE bits: bit i is the ready of channel i.

Function
REQ-011 The block SHALL replicate each input token to all SIZE outputs, delivering it to each output exactly once, independently per channel (eager fork).
REQ-012 The block SHALL hold one state flag per channel, sent[i], meaning "current token already accepted by channel i".
REQ-013 outs[i] SHALL equal ins combinationally for every i; there is no data register and zero-cycle latency.
REQ-014 outs_valid[i] SHALL equal ins_valid AND NOT sent[i], combinationally.
REQ-015 ins_ready SHALL equal the AND over all i of (sent[i] OR outs_ready[i]), combinationally; it depends on outs_ready but never on ins_valid.
REQ-016 Channel i transfers in a cycle when outs_valid[i] AND outs_ready[i].
REQ-017 At a clock edge with ins_valid AND ins_ready, all sent flags SHALL clear to 0 (token retired, next token starts fresh).
REQ-018 Otherwise, at a clock edge, sent[i] SHALL be set to 1 if channel i transfers, and SHALL keep its value if not.
REQ-019 When all channels are ready in the same cycle as ins_valid, the token SHALL complete in that single cycle with no flag ever set.
REQ-020 A channel that has transferred SHALL NOT reassert valid for the same token, regardless of how long other channels stall.
REQ-021 If ins_valid is deasserted while some sent flags are set (protocol violation), the flags SHALL hold; behaviour is otherwise unspecified.
REQ-022 The per-channel state machine has two states: WAIT (sent=0) and DONE (sent=1). WAIT->DONE on transfer without retirement. DONE->WAIT on retirement. All other cases hold.

Reset
REQ-023 While rst is high, all sent flags SHALL be 0 immediately, without waiting for clk.
REQ-024 After reset, outs_valid SHALL equal {SIZE{ins_valid}} and ins_ready SHALL equal AND(outs_ready).
REQ-025 Reset asserted mid-token SHALL discard partial-delivery history; the same token, if still presented, SHALL be re-offered to all channels.

Verification
REQ-026 SIZE=2, ins=0x0000_00AA, ins_valid=1, outs_ready=2'b11 -> same cycle: outs_valid=2'b11, both channels carry 0xAA, ins_ready=1; next cycle sent=2'b00.
REQ-027 SIZE=2, token 0x55 valid, outs_ready=2'b01 for 3 cycles, then 2'b10 -> channel 0 takes 1 transfer, outs_valid=2'b10 for cycles 2-3, ins_ready=1 in cycle 4, exactly one transfer per channel.
REQ-028 SIZE=3, stream of tokens 1..20 with random per-channel outs_ready (~50%) -> each channel receives exactly 1..20 in order, with no duplicates or drops.
REQ-029 SIZE=2, channel 0 accepted, channel 1 stalled, assert rst asynchronously between edges -> outs_valid returns to 2'b11 within the same cycle; after release, token delivered to both channels.
REQ-030 SIZE=4, ins_valid=0, outs_ready toggling -> outs_valid=4'b0000 throughout, sent flags stay 0, no transfers counted.
